cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Run/step/halt controller for the single-cycle CPU on the FPGA board. It replaces direct use of a divided clock with a one-cycle clock-enable pulse, `cpu_en`, generated from the system clock. Period selection is driven from board switches. It sits between the board buttons and switches on one side and the CPU register and PC write-enables on the other. It also latches the CPU halt request (syscall) and counts executed cycles for the LED display.

## Interface
Parameters:
- `DIV0`, default 1_000_000: `cpu_en` period in `clk` cycles when `freq_sel`=0. Must be ≥1.
- `DIV1`, default 10_000_000: period for `freq_sel`=1.
- `DIV2`, default 1_000_000: period for `freq_sel`=2.
- `DIV3`, default 100_000: period for `freq_sel`=3.

Ports:
- `clk`, in, 1: system clock. This is the only clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `run_btn`, in, 1: debounced, synchronous level. A rising edge toggles run/stop.
- `step_btn`, in, 1: debounced, synchronous level. A rising edge issues one `cpu_en` while stopped.
- `halt`, in, 1: CPU halt request, level.
- `freq_sel`, in, 2: period select.
- `cpu_en`, out, 1: registered clock-enable pulse to the CPU.
- `running`, out, 1: high in RUN.
- `halted`, out, 1: high in HALT.
- `freq_cur`, out, 2: period select currently in effect.
- `cycle_count`, out, 32: number of `cpu_en` pulses issued; wraps modulo 2^32.

## Operation
- Edge detect:
  - `run_rise` = `run_btn` & ~`run_q`; `step_rise` = `step_btn` & ~`step_q`.
  - `run_q` and `step_q` are registered every cycle and reset to 1, so a button held through reset produces no edge.
- State machine, one register, states STOP, RUN, HALT:
  - STOP:
    - `run_rise` → RUN. The period counter is cleared and `freq_cur` loads `freq_sel`.
    - Else `step_rise` & ~`halt` → stay in STOP and issue one `cpu_en`.
    - `run_rise` and `step_rise` in the same cycle: run wins and the step is dropped.
  - RUN, checked in priority order:
    - `halt` → HALT.
    - Else `run_rise` → STOP.
    - Else count.
  - HALT: `run_rise` → STOP. All other inputs are ignored.
- Period counter `cnt` (32-bit):
  - Increments only in RUN.
  - When `cnt` = N−1, where N = DIV[`freq_cur`], the next edge sets `cnt`←0, `cpu_en`←1 and `freq_cur`←`freq_sel`.
  - A `freq_sel` change mid-period therefore takes effect only at the next wrap.
  - Holds its value in STOP and HALT, and is cleared on entry to RUN.
- `cpu_en` is registered and is 0 every cycle except the tick or step cycle. It is never high for two consecutive cycles unless N=1.
- `cycle_count` increments on the edge that sets `cpu_en`←1.
- Step is ignored in RUN and HALT, and also in STOP while `halt` is high.
- `halt` is ignored in STOP except for blocking steps.

## Timing
- Reset values:
  - state = STOP
  - `cnt` = 0
  - `cpu_en` = 0
  - `running` = 0
  - `halted` = 0
  - `freq_cur` = 0
  - `cycle_count` = 0
- Reset takes priority over every other input and works from any state, including mid-period. A pending tick is discarded.
- Run entry: `run_rise` seen at edge E0 → `running`=1 after E0.
  - First `cpu_en` is high in the cycle after edge E0+N.
  - Subsequent pulses follow every N cycles while the period select is unchanged.
- Step: `step_rise` seen at edge E → `cpu_en`=1 for exactly the cycle after E. `cycle_count` updates at the same edge.
- Halt: `halt` high at edge E in RUN → `halted`=1 and `running`=0 after E.
  - `cpu_en` is 0 after E even if `cnt` = N−1 at E, because halt beats tick.
  - A `cpu_en` pulse already high during E's preceding cycle is not recalled.
- Stop: `run_rise` at edge E in RUN with `cnt` = N−1 → state becomes STOP and no pulse is issued.
- Period switch: the new N applies from the wrap edge onward. The period in progress completes with the old N.
- `running`, `halted` and `freq_cur` are registered and decoded from the state register, with no combinational input-to-output paths.

## Test plan
Bench parameters: DIV0=4, DIV1=8, DIV2=4, DIV3=2.
- **Reset, then run:** `rst` for 2 cycles, `freq_sel`=0, `run_btn` rises at E0 → `cpu_en` pulses in cycles E0+4, E0+8, E0+12. `cycle_count` = 3 after the third pulse. `running`=1.
- **Period switch:** while running, set `freq_sel`=1 two cycles after a pulse → the next pulse comes 4 cycles after the previous one. Following pulses are 8 apart. `freq_cur` becomes 1 at the wrap edge.
- **Step:** in STOP, three `step_btn` rising edges 5 cycles apart → three single-cycle `cpu_en` pulses, each 1 cycle after its edge, and `cycle_count` = 3. Holding `step_btn` high for 10 cycles produces only one pulse.
- **Halt vs. tick:** raise `halt` on the same edge where `cnt`=3 (DIV0) → no pulse. `halted`=1, `running`=0, and `cycle_count` is unchanged. A later `step_btn` edge has no effect. A `run_btn` edge → STOP.
- **Simultaneous inputs:** in STOP, `run_btn` and `step_btn` rise on the same cycle → RUN is entered, no immediate `cpu_en`, and the first pulse arrives 4 cycles later.
- **Reset mid-operation:** assert `rst` with `cnt`=2 in RUN and `cycle_count`=0xFFFFFFFF (preloaded by forcing) → all outputs return to their reset values the cycle after. Separately, letting `cycle_count` reach 0xFFFFFFFF and then issuing a step wraps it to 0.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
// Run/step/halt controller for the single-cycle CPU. Instead of handing the
// CPU a divided clock, it produces a one-cycle clock-enable pulse (cpu_en) on
// the system clock. In RUN the pulse repeats every DIV[freq_cur] cycles. In
// STOP a step button press issues a single pulse. A CPU halt request parks
// the controller in HALT until the run button is pressed again.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   rst          synchronous, active-high reset
//   run_btn      debounced level; rising edge toggles run/stop (or leaves HALT)
//   step_btn     debounced level; rising edge issues one cpu_en while stopped
//   halt         CPU halt request (level)
//   freq_sel     period select, sampled on run entry and at each period wrap
//   cpu_en       registered clock-enable pulse to the CPU
//   running      high while in RUN
//   halted       high while in HALT
//   freq_cur     period select currently in effect
//   cycle_count  number of cpu_en pulses issued, wraps modulo 2^32
module cpu_clk_ctrl #(
  parameter int unsigned DIV0 = 1_000_000,
  parameter int unsigned DIV1 = 10_000_000,
  parameter int unsigned DIV2 = 1_000_000,
  parameter int unsigned DIV3 = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt,
  input  logic [1:0]  freq_sel,
  output logic        cpu_en,
  output logic        running,
  output logic        halted,
  output logic [1:0]  freq_cur,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cpu_en_q, cpu_en_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;
  logic [1:0]  freq_cur_q, freq_cur_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        run_q, run_d;
  logic        step_q, step_d;

  logic        run_rise;
  logic        step_rise;
  logic [31:0] period_n;
  logic        at_wrap;

  // Button history. Both reset to 1 so a button held through reset is not
  // mistaken for a fresh press.
  assign run_d     = run_btn;
  assign step_d    = step_btn;
  assign run_rise  = run_btn & ~run_q;
  assign step_rise = step_btn & ~step_q;

  // Period of the select currently in effect; freq_sel only reaches this
  // through freq_cur, so a mid-period change waits for the next wrap.
  always_comb begin
    case (freq_cur_q)
      2'd0:    period_n = 32'(DIV0);
      2'd1:    period_n = 32'(DIV1);
      2'd2:    period_n = 32'(DIV2);
      default: period_n = 32'(DIV3);
    endcase
  end

  assign at_wrap = (cnt_q == period_n - 32'd1);

  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cpu_en_d      = 1'b0;
    freq_cur_d    = freq_cur_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_STOP: begin
        if (run_rise) begin
          // Run beats a simultaneous step; the step is simply dropped.
          state_d    = ST_RUN;
          cnt_d      = 32'd0;
          freq_cur_d = freq_sel;
        end else if (step_rise && !halt) begin
          cpu_en_d      = 1'b1;
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end

      ST_RUN: begin
        if (halt) begin
          // Halt beats a tick due on this same edge.
          state_d = ST_HALT;
        end else if (run_rise) begin
          state_d = ST_STOP;
        end else if (at_wrap) begin
          cnt_d         = 32'd0;
          cpu_en_d      = 1'b1;
          freq_cur_d    = freq_sel;
          cycle_count_d = cycle_count_q + 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_HALT: begin
        if (run_rise) begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_STOP;
      end
    endcase

    // Status outputs are decoded from the next state so they are registered
    // alongside it and carry no combinational path from the inputs.
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_STOP;
      cnt_q         <= 32'd0;
      cpu_en_q      <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      freq_cur_q    <= 2'd0;
      cycle_count_q <= 32'd0;
      run_q         <= 1'b1;
      step_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cpu_en_q      <= cpu_en_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
      freq_cur_q    <= freq_cur_d;
      cycle_count_q <= cycle_count_d;
      run_q         <= run_d;
      step_q        <= step_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign freq_cur    = freq_cur_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with DIV0..3 = 4, 8, 4, 2.
// A behavioural model tracks mode, elapsed cycles in the current period and
// pulse count; one process compares every output against it on each falling
// edge. Directed sequences add hand-computed literal expectations, then a
// randomized phase exercises the controller against the model.
module tb_cpu_clk_ctrl;

  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 8;
  localparam int unsigned D2 = 4;
  localparam int unsigned D3 = 2;

  logic        clk;
  logic        rst;
  logic        run_btn;
  logic        step_btn;
  logic        halt;
  logic [1:0]  freq_sel;
  logic        cpu_en;
  logic        running;
  logic        halted;
  logic [1:0]  freq_cur;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_clk_ctrl #(
    .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .halt       (halt),
    .freq_sel   (freq_sel),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .freq_cur   (freq_cur),
    .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int unsigned div_tab [4] = '{D0, D1, D2, D3};
  bit          model_ok = 1'b0;
  bit          m_run, m_halt, m_en;
  int unsigned m_elapsed;
  logic [1:0]  m_freq;
  logic [31:0] m_count;
  bit          p_run, p_step;

  always @(posedge clk) begin : model
    bit rr, sr;
    if (rst) begin
      model_ok  = 1'b1;
      m_run     = 1'b0;
      m_halt    = 1'b0;
      m_en      = 1'b0;
      m_elapsed = 0;
      m_freq    = 2'd0;
      m_count   = 32'd0;
      p_run     = 1'b1;
      p_step    = 1'b1;
    end else begin
      rr     = run_btn && !p_run;
      sr     = step_btn && !p_step;
      p_run  = run_btn;
      p_step = step_btn;
      m_en   = 1'b0;
      if (m_halt) begin
        if (rr) m_halt = 1'b0;
      end else if (m_run) begin
        if (halt) begin
          m_run  = 1'b0;
          m_halt = 1'b1;
        end else if (rr) begin
          m_run = 1'b0;
        end else begin
          // One more cycle of the current period has elapsed; when the
          // full period has gone by, emit a pulse and start a new one.
          m_elapsed++;
          if (m_elapsed == div_tab[m_freq]) begin
            m_elapsed = 0;
            m_en      = 1'b1;
            m_count   = m_count + 32'd1;
            m_freq    = freq_sel;
          end
        end
      end else begin
        if (rr) begin
          m_run     = 1'b1;
          m_elapsed = 0;
          m_freq    = freq_sel;
        end else if (sr && !halt) begin
          m_en    = 1'b1;
          m_count = m_count + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cpu_en",      32'(cpu_en),   32'(m_en));
      check("running",     32'(running),  32'(m_run));
      check("halted",      32'(halted),   32'(m_halt));
      check("freq_cur",    32'(freq_cur), 32'(m_freq));
      check("cycle_count", cycle_count,   m_count);
    end
  end

  // ---------------------------------------------------------------- helpers
  // Advance n cycles; inputs change just after the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Count falling edges until cpu_en is seen high, bounded by max_cyc.
  task automatic measure(input string name, input int exp, input int max_cyc);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!cpu_en && k < max_cyc);
    check(name, 32'(k), 32'(exp));
  endtask

  task automatic preload_count(input logic [31:0] v);
    force dut.cycle_count_q = v;
    m_count = v;
    #1;
    release dut.cycle_count_q;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int pulses;
    rst      = 1'b1;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    freq_sel = 2'd0;
    cyc(2);
    rst = 1'b0;
    check("rst_cpu_en",  32'(cpu_en),   32'd0);
    check("rst_running", 32'(running),  32'd0);
    check("rst_halted",  32'(halted),   32'd0);
    check("rst_freq",    32'(freq_cur), 32'd0);
    check("rst_count",   cycle_count,   32'd0);

    // Reset, then run with N=4.
    cyc(1);
    run_btn = 1'b1;
    cyc(1);
    check("run_entry_running", 32'(running), 32'd1);
    measure("run_first_pulse", 4, 12);
    run_btn = 1'b0;
    measure("run_second_pulse", 4, 12);
    measure("run_third_pulse", 4, 12);
    check("run_count3", cycle_count, 32'd3);
    check("run_running", 32'(running), 32'd1);

    // Period switch two cycles after a pulse: old period completes.
    cyc(2);
    freq_sel = 2'd1;
    measure("switch_old_period", 2, 12);
    check("switch_freq_cur", 32'(freq_cur), 32'd1);
    measure("switch_new_period_a", 8, 16);
    measure("switch_new_period_b", 8, 16);
    check("switch_count", cycle_count, 32'd6);

    // Stop.
    run_btn = 1'b1;
    cyc(1);
    check("stop_running", 32'(running), 32'd0);
    run_btn  = 1'b0;
    freq_sel = 2'd0;

    // Three steps five cycles apart.
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      step_btn = 1'b1;
      measure("step_latency", 1, 4);
      check("step_count", cycle_count, 32'(7 + i));
      step_btn = 1'b0;
      cyc(3);
    end
    // Holding step gives one pulse only.
    step_btn = 1'b1;
    pulses = 0;
    repeat (10) begin
      cyc(1);
      pulses += int'(cpu_en);
    end
    check("step_hold_pulses", 32'(pulses), 32'd1);
    step_btn = 1'b0;
    check("step_hold_count", cycle_count, 32'd10);

    // Halt on the edge where the tick is due.
    cyc(1);
    run_btn = 1'b1;
    cyc(1);
    run_btn = 1'b0;
    cyc(3);
    halt = 1'b1;
    cyc(1);
    check("halt_no_pulse", 32'(cpu_en),  32'd0);
    check("halt_halted",   32'(halted),  32'd1);
    check("halt_running",  32'(running), 32'd0);
    check("halt_count",    cycle_count,  32'd10);
    step_btn = 1'b1;
    cyc(2);
    check("halt_step_ignored", cycle_count, 32'd10);
    step_btn = 1'b0;
    run_btn  = 1'b1;
    cyc(1);
    check("halt_exit_halted",  32'(halted),  32'd0);
    check("halt_exit_running", 32'(running), 32'd0);
    run_btn = 1'b0;
    halt    = 1'b0;

    // Run and step rising together: run wins.
    cyc(1);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    measure("simul_first_pulse", 5, 12);
    check("simul_count",   cycle_count,  32'd11);
    check("simul_running", 32'(running), 32'd1);
    run_btn  = 1'b0;
    step_btn = 1'b0;

    // Reset mid-period with a saturated counter.
    cyc(2);
    freq_sel = 2'd3;
    preload_count(32'hFFFF_FFFF);
    rst = 1'b1;
    cyc(1);
    check("midrst_cpu_en",  32'(cpu_en),   32'd0);
    check("midrst_running", 32'(running),  32'd0);
    check("midrst_halted",  32'(halted),   32'd0);
    check("midrst_freq",    32'(freq_cur), 32'd0);
    check("midrst_count",   cycle_count,   32'd0);
    rst = 1'b0;

    // Counter wrap via a step.
    cyc(1);
    preload_count(32'hFFFF_FFFF);
    step_btn = 1'b1;
    measure("wrap_step", 1, 4);
    check("wrap_count", cycle_count, 32'd0);
    step_btn = 1'b0;

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if ($urandom_range(0, 29) == 0) run_btn = ~run_btn;
      if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 59) == 0) halt = ~halt;
      if ($urandom_range(0, 19) == 0) freq_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
